mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I core. Consumes the MEM_* bundle registered at the EX/MEM boundary and drives the data-memory bus.
//  Runs a req/gnt/rvalid handshake FSM and raises mem_stall while an access is outstanding.
//  Aligns and sign/zero-extends load data and selects the write-back value.
//  Registers the result into the MEM/WB boundary (WB_* outputs) for the register file and forwarding.
// PARAMETERS
//  DATA_WIDTH  32  datapath / bus data width (`DATA_WIDTH)
//  ADDR_WIDTH  5   register-file index width (`ADDR_WIDTH)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  MEM_Mem_r       in   1   load instruction in MEM
//  MEM_Mem_w       in   1   store instruction in MEM
//  MEM_Reg_w       in   1   instruction writes rd
//  MEM_WB_sel      in   2   00 ALU, 01 load data, 10 PC+4, 11 Imm
//  MEM_Imm         in   32  immediate (LUI value)
//  MEM_PC_Plus_4   in   32  link value
//  MEM_ALU_Result  in   32  ALU result / effective address
//  MEM_Mem_W_Data  in   32  store data, already lane-shifted
//  MEM_Rd_Addr     in   5   destination register
//  MEM_Mem_W_Strb  in   4   store byte strobes, already lane-aligned
//  MEM_Funct3      in   3   load size/sign
//  dmem_req        out  1   access request
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  word address {ALU[31:2],2'b00}
//  dmem_wdata      out  32  = MEM_Mem_W_Data
//  dmem_wstrb      out  4   = MEM_Mem_W_Strb when we, else 4'b0000
//  dmem_gnt        in   1   request accepted this cycle
//  dmem_rvalid     in   1   read data valid
//  dmem_rdata      in   32  read data
//  mem_stall       out  1   hold PC, IF/ID, ID/EX, EX/MEM this cycle
//  WB_Reg_w        out  1   registered write enable
//  WB_Rd_Addr      out  5   registered rd
//  WB_Data         out  32  registered write-back value
//  WB_Misaligned   out  1   registered misaligned-load/store flag
// BEHAVIOUR
//  Reset: FSM=IDLE; WB_Reg_w=0, WB_Rd_Addr=0, WB_Data=0, WB_Misaligned=0. Bus outputs are combinational from state and inputs, so dmem_req=0.
//  FSM states:
//   IDLE: dmem_req = MEM_Mem_r|MEM_Mem_w; dmem_we = MEM_Mem_w & ~MEM_Mem_r (read wins if both are set).
//    - read & gnt -> WAIT_R, stall=1.
//    - read & ~gnt -> IDLE, stall=1.
//    - write & gnt -> IDLE, stall=0 (the store completes on gnt).
//    - write & ~gnt -> IDLE, stall=1.
//    - no access -> stall=0.
//   WAIT_R: dmem_req=0.
//    - rvalid -> IDLE, stall=0, load data used this cycle.
//    - ~rvalid -> stall=1.
//  Requests are re-driven each IDLE cycle until gnt. MEM_* inputs are held stable by the stall.
//  rvalid is never expected in the same cycle as gnt and is ignored in IDLE.
//  MEM/WB register: updates on every rising edge where mem_stall=0. While mem_stall=1 it is loaded with a bubble (WB_Reg_w=0), so a stalled instruction is never written back twice.
//  Latency: non-memory ops take 1 cycle to WB_*. A store takes 1 + gnt-wait cycles. A load takes 1 + gnt-wait + rvalid-wait cycles; the minimum is 2.
//  Load extract: byte offset is a = ALU[1:0].
//   - 000 LB: sext rdata[8a+7:8a]
//   - 100 LBU: zext rdata[8a+7:8a]
//   - 001 LH: sext rdata[16a[1]+15:16a[1]]
//   - 101 LHU: zext of the same halfword
//   - 010 LW and any other code: full word
//  WB_Data mux: sel 00 ALU, 01 extracted load, 10 PC+4, 11 Imm.
//  Misaligned: load/store halfword with a[0]=1, or word with a!=0.
//   - The access is still performed, with the data as extracted above.
//   - WB_Misaligned=1 is registered with the result. No trap is raised here.
//  Reset mid-access (e.g. in WAIT_R): return to IDLE at once, WB_* cleared. A late rvalid after reset is ignored.
// TESTING
//  1. Reset with rst_n=0 held for 3 clk -> WB_*=0, dmem_req=0, mem_stall=0. Release -> bubbles flow and WB_Reg_w stays 0.
//  2. ALU op: sel=00, ALU=0x1234, rd=5, Reg_w=1 -> next edge WB_Data=0x1234, WB_Rd_Addr=5, WB_Reg_w=1, no dmem_req.
//  3. LB at ALU=0x103, rdata=0x80FF_0000, gnt at cycle 0, rvalid at cycle 2.
//     -> dmem_addr=0x100; stall=1 for 2 cycles, then WB_Data=0xFFFF_FF80.
//     -> With funct3=100 instead: WB_Data=0x0000_0080.
//  4. SW at 0x200, data 0xDEADBEEF, strb 1111, gnt withheld 3 cycles.
//     -> dmem_req held 4 cycles with stable addr/data; stall=1 for 3 cycles; WB_Reg_w=0 after completion.
//  5. LH at ALU=0x101 -> WB_Misaligned=1 and the load completes normally. sel=10 with PC+4=0x44 -> WB_Data=0x44.
//  6. rst_n pulsed low while in WAIT_R, with rvalid arriving afterwards -> FSM=IDLE, WB_Reg_w=0, late rvalid ignored.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/gnt/rvalid bus between the MEM stage and data memory
//   master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb; samples dmem_gnt, dmem_rvalid, dmem_rdata
//   slave  (memory)   : the mirror image
interface mem_access_stage_if #(parameter int DATA_WIDTH = 32);
  logic                    dmem_req;
  logic                    dmem_we;
  logic [DATA_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb;
  logic                    dmem_gnt;
  logic                    dmem_rvalid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
                  input  dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
                  output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage -- data-memory handshake, load align/extend, MEM/WB register
//   clk, rst_n (async, active-low)
//   MEM_*  : EX/MEM bundle (held stable by mem_stall)
//   bus    : data-memory master port (req/gnt/rvalid)
//   mem_stall : freezes upstream pipeline while an access is outstanding
//   WB_*   : registered MEM/WB outputs
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_Mem_r,
  input  logic                  MEM_Mem_w,
  input  logic                  MEM_Reg_w,
  input  logic [1:0]            MEM_WB_sel,
  input  logic [DATA_WIDTH-1:0] MEM_Imm,
  input  logic [DATA_WIDTH-1:0] MEM_PC_Plus_4,
  input  logic [DATA_WIDTH-1:0] MEM_ALU_Result,
  input  logic [DATA_WIDTH-1:0] MEM_Mem_W_Data,
  input  logic [ADDR_WIDTH-1:0] MEM_Rd_Addr,
  input  logic [3:0]            MEM_Mem_W_Strb,
  input  logic [2:0]            MEM_Funct3,
  mem_access_stage_if.master    bus,
  output logic                  mem_stall,
  output logic                  WB_Reg_w,
  output logic [ADDR_WIDTH-1:0] WB_Rd_Addr,
  output logic [DATA_WIDTH-1:0] WB_Data,
  output logic                  WB_Misaligned
);
  typedef enum logic {IDLE, WAIT_R} state_t;
  state_t state;
  logic [1:0]            a;
  logic                  wr;
  logic [DATA_WIDTH-1:0] sh;
  logic [15:0]           half;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] wb_next;
  logic                  misaligned;
  assign a  = MEM_ALU_Result[1:0];
  // a load takes priority when both access flags are set
  assign wr = MEM_Mem_w & ~MEM_Mem_r;
  always_comb begin
    bus.dmem_req   = (state == IDLE) & (MEM_Mem_r | MEM_Mem_w);
    bus.dmem_we    = (state == IDLE) & wr;
    bus.dmem_addr  = {MEM_ALU_Result[DATA_WIDTH-1:2], 2'b00};
    bus.dmem_wdata = MEM_Mem_W_Data;
    bus.dmem_wstrb = bus.dmem_we ? MEM_Mem_W_Strb : 4'b0000;
    // rvalid only matters in WAIT_R; a store retires on the gnt cycle
    mem_stall = (state == WAIT_R) ? ~bus.dmem_rvalid : (MEM_Mem_r | (wr & ~bus.dmem_gnt));
  end
  always_comb begin
    sh   = bus.dmem_rdata >> {a, 3'b000};
    half = a[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_data = (MEM_Funct3[1:0] == 2'b00) ? {{24{sh[7] & ~MEM_Funct3[2]}}, sh[7:0]} :
                (MEM_Funct3[1:0] == 2'b01) ? {{16{half[15] & ~MEM_Funct3[2]}}, half} :
                bus.dmem_rdata;
    wb_next = (MEM_WB_sel == 2'b00) ? MEM_ALU_Result :
              (MEM_WB_sel == 2'b01) ? load_data :
              (MEM_WB_sel == 2'b10) ? MEM_PC_Plus_4 : MEM_Imm;
    misaligned = (MEM_Mem_r | MEM_Mem_w) &
                 ((MEM_Funct3[1:0] == 2'b01) ? a[0] :
                  (MEM_Funct3[1:0] == 2'b00) ? 1'b0 : (a != 2'b00));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      WB_Reg_w      <= 1'b0;
      WB_Rd_Addr    <= '0;
      WB_Data       <= '0;
      WB_Misaligned <= 1'b0;
    end else begin
      state <= (state == IDLE) ? ((MEM_Mem_r & bus.dmem_gnt) ? WAIT_R : IDLE) :
               (bus.dmem_rvalid ? IDLE : WAIT_R);
      // a stalled instruction leaves a bubble so it is written back exactly once
      if (mem_stall) begin
        WB_Reg_w      <= 1'b0;
        WB_Misaligned <= 1'b0;
      end else begin
        WB_Reg_w      <= MEM_Reg_w;
        WB_Rd_Addr    <= MEM_Rd_Addr;
        WB_Data       <= wb_next;
        WB_Misaligned <= misaligned;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_Mem_r, MEM_Mem_w, MEM_Reg_w;
  logic [1:0]  MEM_WB_sel;
  logic [31:0] MEM_Imm, MEM_PC_Plus_4, MEM_ALU_Result, MEM_Mem_W_Data;
  logic [4:0]  MEM_Rd_Addr;
  logic [3:0]  MEM_Mem_W_Strb;
  logic [2:0]  MEM_Funct3;
  logic        mem_stall, WB_Reg_w, WB_Misaligned;
  logic [4:0]  WB_Rd_Addr;
  logic [31:0] WB_Data;
  int n_cmp = 0;
  int n_err = 0;
  mem_access_stage_if #(.DATA_WIDTH(32)) bus ();
  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_Mem_r(MEM_Mem_r), .MEM_Mem_w(MEM_Mem_w), .MEM_Reg_w(MEM_Reg_w),
    .MEM_WB_sel(MEM_WB_sel), .MEM_Imm(MEM_Imm), .MEM_PC_Plus_4(MEM_PC_Plus_4),
    .MEM_ALU_Result(MEM_ALU_Result), .MEM_Mem_W_Data(MEM_Mem_W_Data),
    .MEM_Rd_Addr(MEM_Rd_Addr), .MEM_Mem_W_Strb(MEM_Mem_W_Strb), .MEM_Funct3(MEM_Funct3),
    .bus(bus.master), .mem_stall(mem_stall),
    .WB_Reg_w(WB_Reg_w), .WB_Rd_Addr(WB_Rd_Addr), .WB_Data(WB_Data), .WB_Misaligned(WB_Misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    MEM_Mem_r = 0; MEM_Mem_w = 0; MEM_Reg_w = 0; MEM_WB_sel = 0;
    MEM_Imm = 0; MEM_PC_Plus_4 = 0; MEM_ALU_Result = 0; MEM_Mem_W_Data = 0;
    MEM_Rd_Addr = 0; MEM_Mem_W_Strb = 0; MEM_Funct3 = 0;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // load granted on its first cycle, rvalid two cycles after the request
  task automatic run_load(input string tag, input logic [31:0] alu, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp_data, input logic exp_mis);
    clr();
    MEM_Mem_r = 1; MEM_Reg_w = 1; MEM_WB_sel = 2'b01; MEM_Funct3 = f3;
    MEM_ALU_Result = alu; MEM_Rd_Addr = 5'd9; MEM_Mem_W_Strb = 4'hF; bus.dmem_gnt = 1;
    #1;
    chk({tag, "_req"}, bus.dmem_req, 1);
    chk({tag, "_wstrb"}, bus.dmem_wstrb, 0);
    chk({tag, "_stall0"}, mem_stall, 1);
    tick();
    bus.dmem_gnt = 0;
    #1;
    chk({tag, "_stall1"}, mem_stall, 1);
    tick();
    bus.dmem_rvalid = 1; bus.dmem_rdata = rdata;
    #1;
    chk({tag, "_stall2"}, mem_stall, 0);
    tick();
    clr();
    chk({tag, "_data"}, WB_Data, exp_data);
    chk({tag, "_mis"}, WB_Misaligned, exp_mis);
    chk({tag, "_regw"}, WB_Reg_w, 1);
  endtask
  initial begin
    clr();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_reg_w", WB_Reg_w, 0);
    chk("rst_wb_rd", WB_Rd_Addr, 0);
    chk("rst_wb_data", WB_Data, 0);
    chk("rst_wb_mis", WB_Misaligned, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    rst_n = 1;
    tick();
    tick();
    chk("bubble_reg_w", WB_Reg_w, 0);
    // ALU op
    MEM_Reg_w = 1; MEM_WB_sel = 2'b00; MEM_ALU_Result = 32'h1234; MEM_Rd_Addr = 5'd5;
    #1;
    chk("alu_req", bus.dmem_req, 0);
    chk("alu_stall", mem_stall, 0);
    tick();
    chk("alu_data", WB_Data, 32'h1234);
    chk("alu_rd", WB_Rd_Addr, 5);
    chk("alu_regw", WB_Reg_w, 1);
    // LB at 0x103, explicit cycle-by-cycle
    clr();
    MEM_Mem_r = 1; MEM_Reg_w = 1; MEM_WB_sel = 2'b01; MEM_Funct3 = 3'b000;
    MEM_ALU_Result = 32'h103; MEM_Rd_Addr = 5'd7; bus.dmem_gnt = 1;
    #1;
    chk("lb_addr", bus.dmem_addr, 32'h100);
    chk("lb_req", bus.dmem_req, 1);
    chk("lb_we", bus.dmem_we, 0);
    chk("lb_stall0", mem_stall, 1);
    tick();
    bus.dmem_gnt = 0;
    #1;
    chk("lb_wait_req", bus.dmem_req, 0);
    chk("lb_stall1", mem_stall, 1);
    chk("lb_bubble", WB_Reg_w, 0);
    tick();
    chk("lb_bubble2", WB_Reg_w, 0);
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb_stall2", mem_stall, 0);
    tick();
    clr();
    chk("lb_data", WB_Data, 32'hFFFF_FF80);
    chk("lb_rd", WB_Rd_Addr, 7);
    chk("lb_regw", WB_Reg_w, 1);
    chk("lb_mis", WB_Misaligned, 0);
    run_load("lbu", 32'h103, 3'b100, 32'h80FF_0000, 32'h0000_0080, 0);
    run_load("lb1", 32'h101, 3'b000, 32'h0000_F100, 32'hFFFF_FFF1, 0);
    run_load("lh_mis", 32'h101, 3'b001, 32'h1234_8001, 32'hFFFF_8001, 1);
    run_load("lhu", 32'h102, 3'b101, 32'h9ABC_0000, 32'h0000_9ABC, 0);
    run_load("lh_hi", 32'h102, 3'b001, 32'h7ABC_FFFF, 32'h0000_7ABC, 0);
    run_load("lw", 32'h104, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
    run_load("lw_mis", 32'h106, 3'b010, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 1);
    // SW with gnt withheld 3 cycles
    MEM_Mem_w = 1; MEM_ALU_Result = 32'h200; MEM_Mem_W_Data = 32'hDEAD_BEEF;
    MEM_Mem_W_Strb = 4'hF; MEM_Funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_req", bus.dmem_req, 1);
      chk("sw_we", bus.dmem_we, 1);
      chk("sw_addr", bus.dmem_addr, 32'h200);
      chk("sw_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
      chk("sw_wstrb", bus.dmem_wstrb, 32'hF);
      chk("sw_stall", mem_stall, 1);
      tick();
    end
    bus.dmem_gnt = 1;
    #1;
    chk("sw_gnt_req", bus.dmem_req, 1);
    chk("sw_gnt_stall", mem_stall, 0);
    tick();
    clr();
    chk("sw_regw", WB_Reg_w, 0);
    chk("sw_mis", WB_Misaligned, 0);
    // PC+4 and immediate selection
    MEM_Reg_w = 1; MEM_WB_sel = 2'b10; MEM_PC_Plus_4 = 32'h44; MEM_Rd_Addr = 5'd1;
    MEM_Imm = 32'hABCD_0000; MEM_ALU_Result = 32'h55;
    tick();
    chk("pc4_data", WB_Data, 32'h44);
    chk("pc4_rd", WB_Rd_Addr, 1);
    MEM_WB_sel = 2'b11;
    tick();
    chk("imm_data", WB_Data, 32'hABCD_0000);
    // reset while waiting for rvalid
    clr();
    MEM_Mem_r = 1; MEM_Reg_w = 1; MEM_WB_sel = 2'b01; MEM_ALU_Result = 32'h100;
    MEM_Rd_Addr = 5'd3; MEM_Funct3 = 3'b010; bus.dmem_gnt = 1;
    tick();
    bus.dmem_gnt = 0;
    #1;
    chk("rw_wait_req", bus.dmem_req, 0);
    rst_n = 0;
    #1;
    chk("rw_idle_req", bus.dmem_req, 1);
    chk("rw_regw", WB_Reg_w, 0);
    chk("rw_data", WB_Data, 0);
    tick();
    rst_n = 1;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h1111_2222;
    #1;
    chk("rw_late_stall", mem_stall, 1);
    tick();
    chk("rw_late_regw", WB_Reg_w, 0);
    chk("rw_late_data", WB_Data, 0);
    chk("rw_still_idle", bus.dmem_req, 1);
    clr();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
